reg_file_mp: RTL

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 116 +++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file with a busy scoreboard for long-latency results.
// Two write ports (A wins on conflict), combinational reads, optional bypass.
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_a,
  input  logic [AW-1:0]       wr_addr_a,
  input  logic [XLEN-1:0]     wr_data_a,
  input  logic                wr_en_b,
  input  logic [AW-1:0]       wr_addr_b,
  input  logic [XLEN-1:0]     wr_data_b,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  output logic [AW:0]         busy_count
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [AW:0]     busyCount;
  logic            wrA;
  logic            wrB;
  logic            rsv;
  logic            incCnt;
  logic            decCnt;

  function automatic logic addrOk(input logic [AW-1:0] a);
    return (int'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Gating with reset also kills bypass while reset is held.
  assign wrA = wr_en_a && !reset && addrOk(wr_addr_a);
  assign wrB = wr_en_b && !reset && addrOk(wr_addr_b);
  assign rsv = rsv_en && !reset && addrOk(rsv_addr);

  always_comb begin
    incCnt = 1'b0;
    decCnt = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (rsv && rsv_addr == AW'(r) && !busy[r])
        incCnt = 1'b1;
      if (wrB && wr_addr_b == AW'(r) && busy[r] &&
          !(rsv && rsv_addr == wr_addr_b))
        decCnt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++)
        regs[r] <= '0;
      busy      <= '0;
      busyCount <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wrA && wr_addr_a == AW'(r))
          regs[r] <= wr_data_a;
        else if (wrB && wr_addr_b == AW'(r))
          regs[r] <= wr_data_b;
        // Reservation beats completion on the same register.
        if (rsv && rsv_addr == AW'(r))
          busy[r] <= 1'b1;
        else if (wrB && wr_addr_b == AW'(r))
          busy[r] <= 1'b0;
      end
      if (incCnt && !decCnt)
        busyCount <= busyCount + (AW+1)'(1);
      else if (decCnt && !incCnt)
        busyCount <= busyCount - (AW+1)'(1);
    end
  end

  assign busy_count = busyCount;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] stored;
    logic            stBusy;
    logic            hitA;
    logic            hitB;

    assign a = rd_addr[i*AW +: AW];

    always_comb begin
      stored = '0;
      stBusy = 1'b0;
      for (int r = 0; r < NREG; r++) begin
        if (a == AW'(r)) begin
          stored = regs[r];
          stBusy = busy[r];
        end
      end
    end

    assign hitA = (BYPASS != 0) && wrA && (wr_addr_a == a);
    assign hitB = (BYPASS != 0) && wrB && (wr_addr_b == a);

    assign rd_data[i*XLEN +: XLEN] =
      !addrOk(a) ? '0        :
      hitA       ? wr_data_a :
      hitB       ? wr_data_b :
                   stored;

    assign rd_busy[i] = addrOk(a) && stBusy && !hitB;
  end

endmodule
